// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC types and constants for the data-memory stage.
package simplerisc_pkg;

  localparam int unsigned DM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dm_state_t;

  localparam logic [1:0] DM_ERR_NONE     = 2'b00;
  localparam logic [1:0] DM_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] DM_ERR_LDST     = 2'b10;
  localparam logic [1:0] DM_ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/dm_timeout_ctr.sv
// Saturating wait counter for the DM bus; hit_c flags the last allowed BUSY cycle.
module dm_timeout_ctr #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic hit_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en && cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign hit_c = (cnt == CNT_HIT);

endmodule

// File: rtl/dm_access_unit.sv
// DM-stage access unit: turns ld/st into a req/ack bus transaction and stalls the pipe until it ends.
module dm_access_unit
  import simplerisc_pkg::*;
#(
  parameter int unsigned DATA_W  = DM_DATA_W,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              isLd_DM,
  input  logic              isSt_DM,
  input  logic [DATA_W-1:0] aluResult_DM,
  input  logic [DATA_W-1:0] op2_DM,
  output logic [DATA_W-1:0] DMResult_DM,
  output logic              stall_DM,
  output logic [1:0]        err_DM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  dm_state_t         state, state_nxt;
  logic              req_nxt, we_nxt;
  logic [DATA_W-1:0] addr_nxt, wdata_nxt, result_nxt;
  logic [1:0]        err_nxt;
  logic              ctr_clr, ctr_en, ctr_hit;

  dm_timeout_ctr #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk  (clk),
    .reset(reset),
    .clear(ctr_clr),
    .en   (ctr_en),
    .hit_c(ctr_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      DMResult_DM <= '0;
      err_DM      <= DM_ERR_NONE;
    end else begin
      state       <= state_nxt;
      mem_req     <= req_nxt;
      mem_we      <= we_nxt;
      mem_addr    <= addr_nxt;
      mem_wdata   <= wdata_nxt;
      DMResult_DM <= result_nxt;
      err_DM      <= err_nxt;
    end
  end

  // Illegal ops only raise an error pulse; they never stall or reach the bus.
  always_comb begin
    state_nxt  = state;
    req_nxt    = mem_req;
    we_nxt     = mem_we;
    addr_nxt   = mem_addr;
    wdata_nxt  = mem_wdata;
    result_nxt = DMResult_DM;
    err_nxt    = DM_ERR_NONE;
    ctr_clr    = 1'b0;
    ctr_en     = 1'b0;
    stall_DM   = 1'b0;
    case (state)
      IDLE: begin
        if (isLd_DM || isSt_DM) begin
          if (isLd_DM && isSt_DM) begin
            err_nxt = DM_ERR_LDST;
          end else if (aluResult_DM[1:0] != 2'b00) begin
            err_nxt = DM_ERR_MISALIGN;
          end else begin
            stall_DM  = 1'b1;
            req_nxt   = 1'b1;
            we_nxt    = isSt_DM;
            addr_nxt  = aluResult_DM;
            wdata_nxt = op2_DM;
            ctr_clr   = 1'b1;
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        stall_DM = 1'b1;
        if (mem_ack) begin
          req_nxt = 1'b0;
          if (!mem_we) begin
            result_nxt = mem_rdata;
          end
          state_nxt = DONE;
        end else if (ctr_hit) begin
          req_nxt   = 1'b0;
          err_nxt   = DM_ERR_TIMEOUT;
          state_nxt = DONE;
        end else begin
          ctr_en = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
